cache_mem_burst_master: RTL

- Upstream master for main_memory: converts cache line refill/writeback requests into AXI4 INCR bursts on its slave interface.
- Sits between the coherence controller and main_memory; one outstanding transaction, no reordering.
- Read returns the full line in one response; write sends the full line and returns BRESP status.

---
 rtl/cache_mem_pkg.sv | 22 ++
 rtl/cache_mem_burst_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache line AXI4 burst master.
package cache_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_RESP
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Number of byte-address bits covered by one cache line.
  function automatic int line_off_width(input int line_words, input int data_width);
    return $clog2(line_words * data_width / 8);
  endfunction

endpackage

// File: rtl/cache_mem_burst_master.sv
// Cache line refill/writeback engine issuing one AXI4 INCR burst per request.
// Optional MEM_RLAST_CHECK_EN flags RLAST placement errors in resp_err.
//
// state   | meaning
// IDLE    | ready for a line request
// AR      | read address offered, waiting for ARREADY
// R       | collecting LINE_WORDS read beats into the line buffer
// AW      | write address offered, waiting for AWREADY
// W       | streaming LINE_WORDS write beats from the line buffer
// B       | waiting for the write response
// RESP    | completion presented upstream, waiting for resp_ready
module cache_mem_burst_master
  import cache_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wline,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_rline,
  output logic                             resp_err,
  output logic [ID_WIDTH-1:0]              m_AWID,
  output logic [ADDR_WIDTH-1:0]            m_AWADDR,
  output logic [7:0]                       m_AWLEN,
  output logic [2:0]                       m_AWSIZE,
  output logic [1:0]                       m_AWBURST,
  output logic                             m_AWLOCK,
  output logic [3:0]                       m_AWCACHE,
  output logic [2:0]                       m_AWPROT,
  output logic [3:0]                       m_AWQOS,
  output logic [3:0]                       m_AWREGION,
  output logic [USER_WIDTH-1:0]            m_AWUSER,
  output logic                             m_AWVALID,
  input  logic                             m_AWREADY,
  output logic [DATA_WIDTH-1:0]            m_WDATA,
  output logic [DATA_WIDTH/8-1:0]          m_WSTRB,
  output logic                             m_WLAST,
  output logic [USER_WIDTH-1:0]            m_WUSER,
  output logic                             m_WVALID,
  input  logic                             m_WREADY,
  input  logic [ID_WIDTH-1:0]              m_BID,
  input  logic [1:0]                       m_BRESP,
  input  logic [USER_WIDTH-1:0]            m_BUSER,
  input  logic                             m_BVALID,
  output logic                             m_BREADY,
  output logic [ID_WIDTH-1:0]              m_ARID,
  output logic [ADDR_WIDTH-1:0]            m_ARADDR,
  output logic [7:0]                       m_ARLEN,
  output logic [2:0]                       m_ARSIZE,
  output logic [1:0]                       m_ARBURST,
  output logic                             m_ARLOCK,
  output logic [3:0]                       m_ARCACHE,
  output logic [2:0]                       m_ARPROT,
  output logic [3:0]                       m_ARQOS,
  output logic [3:0]                       m_ARREGION,
  output logic [USER_WIDTH-1:0]            m_ARUSER,
  output logic                             m_ARVALID,
  input  logic                             m_ARREADY,
  input  logic [ID_WIDTH-1:0]              m_RID,
  input  logic [DATA_WIDTH-1:0]            m_RDATA,
  input  logic [1:0]                       m_RRESP,
  input  logic                             m_RLAST,
  input  logic [USER_WIDTH-1:0]            m_RUSER,
  input  logic                             m_RVALID,
  output logic                             m_RREADY
);

  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = line_off_width(LINE_WORDS, DATA_WIDTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t              state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_W-1:0]   line_q;
  logic [BEAT_W-1:0]   beat;
  logic                err_q;
  logic                rresp_bad;
  logic                rlast_bad;

  assign rresp_bad = (m_RRESP != AXI_RESP_OKAY);
`ifdef MEM_RLAST_CHECK_EN
  assign rlast_bad = (m_RLAST != (beat == LAST_BEAT));
`else
  assign rlast_bad = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      line_q <= '0;
      beat   <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (req_valid) begin
          addr_q <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          line_q <= req_wline;
          beat   <= '0;
          err_q  <= 1'b0;
        end
        ST_AR: if (m_ARREADY) beat <= '0;
        ST_R: if (m_RVALID) begin
          line_q[beat*DATA_WIDTH +: DATA_WIDTH] <= m_RDATA;
          beat  <= beat + 1'b1;
          err_q <= err_q | rresp_bad | rlast_bad;
        end
        ST_W: if (m_WREADY) beat <= beat + 1'b1;
        ST_B: if (m_BVALID && (m_BRESP != AXI_RESP_OKAY)) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    m_ARVALID  = 1'b0;
    m_RREADY   = 1'b0;
    m_AWVALID  = 1'b0;
    m_WVALID   = 1'b0;
    m_BREADY   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_we ? ST_AW : ST_AR;
      end
      ST_AR: begin
        m_ARVALID = 1'b1;
        if (m_ARREADY) state_nxt = ST_R;
      end
      ST_R: begin
        m_RREADY = 1'b1;
        // Beat count alone ends the burst, even if RLAST disagrees.
        if (m_RVALID && (beat == LAST_BEAT)) state_nxt = ST_RESP;
      end
      ST_AW: begin
        m_AWVALID = 1'b1;
        if (m_AWREADY) state_nxt = ST_W;
      end
      ST_W: begin
        m_WVALID = 1'b1;
        if (m_WREADY && (beat == LAST_BEAT)) state_nxt = ST_B;
      end
      ST_B: begin
        m_BREADY = 1'b1;
        if (m_BVALID) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign resp_rline = line_q;
  assign resp_err   = err_q;

  assign m_ARID     = '0;
  assign m_ARADDR   = addr_q;
  assign m_ARLEN    = 8'(LINE_WORDS - 1);
  assign m_ARSIZE   = 3'($clog2(DATA_WIDTH / 8));
  assign m_ARBURST  = AXI_BURST_INCR;
  assign m_ARLOCK   = 1'b0;
  assign m_ARCACHE  = '0;
  assign m_ARPROT   = '0;
  assign m_ARQOS    = '0;
  assign m_ARREGION = '0;
  assign m_ARUSER   = '0;

  assign m_AWID     = '0;
  assign m_AWADDR   = addr_q;
  assign m_AWLEN    = 8'(LINE_WORDS - 1);
  assign m_AWSIZE   = 3'($clog2(DATA_WIDTH / 8));
  assign m_AWBURST  = AXI_BURST_INCR;
  assign m_AWLOCK   = 1'b0;
  assign m_AWCACHE  = '0;
  assign m_AWPROT   = '0;
  assign m_AWQOS    = '0;
  assign m_AWREGION = '0;
  assign m_AWUSER   = '0;

  assign m_WDATA = line_q[beat*DATA_WIDTH +: DATA_WIDTH];
  assign m_WSTRB = '1;
  assign m_WLAST = (state == ST_W) && (beat == LAST_BEAT);
  assign m_WUSER = '0;

  // Response IDs/user bits carry nothing for a single-ID, in-order master.
  logic unused_inputs;
  assign unused_inputs = ^{m_BID, m_BUSER, m_RID, m_RUSER, m_RLAST, req_addr[OFF_W-1:0]};

endmodule
